bram_dump_reader: RTL and testbench

- Readback sequencer for the inferred simple-dual-port BRAM used by the single-port-width tests; drives the memory's read address and consumes its registered read data.
- On a start pulse it sweeps addresses 0..DEPTH_MEM-1 and streams each (address, word) pair to a downstream consumer over a valid/ready handshake.
- Also produces a running checksum, so benches and on-chip logic can confirm that patched init contents match the expected image without a full dump.

---
 rtl/bram_dump_pkg.sv | 29 ++
 rtl/bram_dump_reader_if.sv | 39 +++
 rtl/bram_dump_skid_buf.sv | 52 +++++
 rtl/bram_dump_reader.sv | 127 ++++++++++++
 tb/tb_bram_dump_reader.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dump_pkg
//  Description : Shared types and constants for the BRAM readback sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package bram_dump_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BUF_DEPTH = 2;
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

   // A slot is free if the word popped this cycle makes room for the read
   // issued this cycle; this is what lets a held-ready consumer get one word
   // per cycle out of a two-entry buffer.
   function automatic logic credit_ok(input logic [CNT_W-1:0] count,
                                      input logic             pop,
                                      input logic             in_flight);
      return (int'(count) - int'(pop) + int'(in_flight)) < BUF_DEPTH;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_dump_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dump_reader_if
//  Description : Memory read port plus valid/ready word stream of the reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface bram_dump_reader_if #(
   parameter int ADDR_W  = 17,
   parameter int WID_MEM = 16
);
   logic [ADDR_W-1:0]  mem_raddr;
   logic [WID_MEM-1:0] mem_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [ADDR_W-1:0]  out_addr;
   logic [WID_MEM-1:0] out_data;
   logic               out_last;

   modport master (
      output mem_raddr,
      input  mem_rdata,
      output out_valid,
      input  out_ready,
      output out_addr,
      output out_data,
      output out_last
   );

   modport slave (
      input  mem_raddr,
      output mem_rdata,
      input  out_valid,
      output out_ready,
      input  out_addr,
      input  out_data,
      input  out_last
   );
endinterface
`default_nettype wire

// File: rtl/bram_dump_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dump_skid_buf
//  Description : Two-entry FIFO of address/data pairs feeding the output port.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_dump_skid_buf
   import bram_dump_pkg::*;
#(
   parameter type entry_t = logic [32:0]
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  entry_t           push_entry,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output entry_t           head
);

   entry_t slots [BUF_DEPTH];
   logic   wr_ptr;
   logic   rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            slots[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            slots[wr_ptr] <= push_entry;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = slots[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/bram_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dump_reader
//  Description : Sweeps a registered-read BRAM 0..DEPTH_MEM-1, streams each
//                (address, word) pair and accumulates a running checksum.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_dump_reader
   import bram_dump_pkg::*;
#(
   parameter int WID_MEM   = 16,
   parameter int DEPTH_MEM = 131072,
   parameter int ADDR_W    = 17,
   parameter int CSUM_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   bram_dump_reader_if.master bus,
   output logic               busy,
   output logic               done,
   output logic [CSUM_W-1:0]  checksum
);

   // Packages cannot take parameters, so the entry type lives here where the
   // widths are known and is handed to the buffer as a type parameter.
   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [WID_MEM-1:0] data;
   } entry_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] issue_ptr;
   logic [ADDR_W-1:0] raddr_hold;
   logic              in_flight;
   logic              issue;
   logic              start_sweep;
   logic              pop;
   logic              buf_valid;
   logic [CNT_W-1:0]  count;
   entry_t            head;
   entry_t            push_entry;

   always_comb begin
      state_nxt   = state;
      issue       = 1'b0;
      start_sweep = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt   = RUN;
               start_sweep = 1'b1;
            end
         end
         RUN: begin
            issue = credit_ok(count, pop, in_flight);
            if (issue && (issue_ptr == LAST_ADDR)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Leave on the edge of the final handshake so done shows next cycle.
            if (!in_flight && (count == CNT_W'(pop))) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         issue_ptr  <= '0;
         raddr_hold <= '0;
         in_flight  <= 1'b0;
         checksum   <= '0;
      end else begin
         state     <= state_nxt;
         in_flight <= issue;
         if (issue) begin
            raddr_hold <= issue_ptr;
            if (issue_ptr != LAST_ADDR) begin
               issue_ptr <= issue_ptr + ADDR_W'(1);
            end
         end
         if (start_sweep) begin
            issue_ptr <= '0;
            checksum  <= '0;
         end else if (pop) begin
            checksum <= checksum + CSUM_W'(head.data);
         end
      end
   end

   // raddr_hold is also the address of the read currently in flight.
   assign push_entry = '{addr: raddr_hold, data: bus.mem_rdata};

   bram_dump_skid_buf #(
      .entry_t (entry_t)
   ) u_skid_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (in_flight),
      .push_entry (push_entry),
      .pop        (pop),
      .count      (count),
      .head       (head)
   );

   assign buf_valid     = (count != '0);
   assign pop           = buf_valid && bus.out_ready;

   assign bus.mem_raddr = issue ? issue_ptr : raddr_hold;
   assign bus.out_valid = buf_valid;
   assign bus.out_addr  = buf_valid ? head.addr : '0;
   assign bus.out_data  = buf_valid ? head.data : '0;
   assign bus.out_last  = buf_valid && (head.addr == LAST_ADDR);

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bram_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_dump_reader
//  Description : Self-checking bench for bram_dump_reader against a sweep model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_dump_reader;

   localparam int D  = 8;
   localparam int AW = 3;
   localparam int WD = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic ready = 1'b0;

   logic        busy_a, done_a, busy_b, done_b;
   logic [31:0] csum_a;
   logic [15:0] csum_b;
   logic [WD-1:0] mem_a [D];

   int passed = 0;
   int total  = 0;

   // observations of the most recent sweep
   int          h_addr[$], h_data[$], h_last[$], h_cyc[$];
   int          first_valid, done_cyc, stab_err, ahead_err, stall_err;
   logic        k1_done, k1_busy, busy_at_done, done_b_at_done;
   logic [31:0] k1_csum, csum_at_done;
   logic [15:0] csum_b_at_done;

   always #5 clk = ~clk;

   bram_dump_reader_if #(.ADDR_W(AW), .WID_MEM(WD)) bus_a ();
   bram_dump_reader_if #(.ADDR_W(AW), .WID_MEM(WD)) bus_b ();

   assign bus_a.out_ready = ready;
   assign bus_b.out_ready = ready;

   always @(posedge clk) bus_a.mem_rdata <= mem_a[bus_a.mem_raddr];
   always @(posedge clk) bus_b.mem_rdata <= 16'hFFFF;

   bram_dump_reader #(.WID_MEM(WD), .DEPTH_MEM(D), .ADDR_W(AW), .CSUM_W(32)) dut_a (
      .clk(clk), .reset(rst_n), .start(start), .bus(bus_a),
      .busy(busy_a), .done(done_a), .checksum(csum_a));

   bram_dump_reader #(.WID_MEM(WD), .DEPTH_MEM(D), .ADDR_W(AW), .CSUM_W(16)) dut_b (
      .clk(clk), .reset(rst_n), .start(start), .bus(bus_b),
      .busy(busy_b), .done(done_b), .checksum(csum_b));

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return ((k % 4) == 0) || ((k % 4) == 3);
         2:       return k > 20;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Reference: a sweep delivers every address once, in order, with its word.
   function automatic logic [31:0] model_sum();
      logic [31:0] s = 0;
      for (int i = 0; i < D; i++) s = s + 32'(mem_a[i]);
      return s;
   endfunction

   function automatic int model_mismatches();
      int m = 0;
      if (h_addr.size() != D) return D + 1;
      for (int i = 0; i < D; i++)
         if (h_addr[i] != i || h_data[i] != int'(mem_a[i]) || h_last[i] != int'(i == D - 1)) m++;
      return m;
   endfunction

   task automatic load_ramp();
      for (int i = 0; i < D; i++) mem_a[i] = WD'(16'h1000 + i);
   endtask

   task automatic sweep(input int mode, input bit inj_mid, input bit inj_last);
      logic          pstall;
      logic [AW-1:0] paddr;
      logic [WD-1:0] pdata;
      bit            injected;
      h_addr.delete(); h_data.delete(); h_last.delete(); h_cyc.delete();
      first_valid = -1; done_cyc = -1; stab_err = 0; ahead_err = 0; stall_err = 0;
      pstall = 1'b0; paddr = '0; pdata = '0; injected = 1'b0;
      @(negedge clk);
      start = 1'b1;
      ready = ready_for(mode, 0);
      for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         ready = ready_for(mode, k);
         #1;
         if (k == 1) begin
            k1_done = done_a; k1_busy = busy_a; k1_csum = csum_a;
         end
         if (pstall && (!bus_a.out_valid || bus_a.out_addr !== paddr || bus_a.out_data !== pdata))
            stab_err++;
         if (bus_a.out_valid && int'(bus_a.mem_raddr) > int'(bus_a.out_addr) + 2)
            ahead_err++;
         if (mode == 2 && k >= 5 && k <= 20 &&
             (!bus_a.out_valid || bus_a.out_addr !== 3'd0 || bus_a.out_data !== 16'h1000 ||
              bus_a.mem_raddr !== 3'd1))
            stall_err++;
         if (bus_a.out_valid && first_valid < 0) first_valid = k;
         if (done_a) begin
            done_cyc = k; busy_at_done = busy_a; csum_at_done = csum_a;
            csum_b_at_done = csum_b; done_b_at_done = done_b;
         end
         if (bus_a.out_valid && ready) begin
            h_addr.push_back(int'(bus_a.out_addr));
            h_data.push_back(int'(bus_a.out_data));
            h_last.push_back(int'(bus_a.out_last));
            h_cyc.push_back(k);
            if (inj_mid && !injected && bus_a.out_addr == 3'd4) begin
               start = 1'b1; injected = 1'b1;
            end
            if (inj_last && bus_a.out_last) start = 1'b1;
         end
         pstall = bus_a.out_valid && !ready;
         paddr  = bus_a.out_addr;
         pdata  = bus_a.out_data;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (bus_a.mem_raddr === 3'd0 && bus_a.out_valid === 1'b0 && bus_a.out_last === 1'b0) passed++;
      else $display("FAIL reset_port: raddr=%0d valid=%b last=%b, required 0/0/0",
                    bus_a.mem_raddr, bus_a.out_valid, bus_a.out_last);
      total++;
      if (bus_a.out_addr === 3'd0 && bus_a.out_data === 16'h0) passed++;
      else $display("FAIL reset_out: addr=%0d data=%h, required 0/0000", bus_a.out_addr, bus_a.out_data);
      total++;
      if (busy_a === 1'b0 && done_a === 1'b0 && csum_a === 32'h0) passed++;
      else $display("FAIL reset_status: busy=%b done=%b csum=%h, required 0/0/0", busy_a, done_a, csum_a);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_rate();
      int m;
      load_ramp();
      sweep(0, 1'b0, 1'b0);
      m = model_mismatches();
      total++;
      if (m == 0) passed++;
      else $display("FAIL full_seq: %0d bad words of %0d seen, required 0 of %0d", m, h_addr.size(), D);
      total++;
      if (csum_at_done === 32'h0000801C && csum_at_done === model_sum()) passed++;
      else $display("FAIL full_csum: got %h, required %h", csum_at_done, model_sum());
      total++;
      if (first_valid == 3) passed++;
      else $display("FAIL full_latency: first valid at cycle %0d, required 3", first_valid);
      m = 0;
      for (int i = 0; i < h_cyc.size(); i++) if (h_cyc[i] != 3 + i) m++;
      total++;
      if (m == 0 && h_cyc.size() == D) passed++;
      else $display("FAIL full_rate: %0d gaps in %0d handshakes, required 0 in %0d", m, h_cyc.size(), D);
      total++;
      if (h_cyc.size() > 0 && done_cyc == h_cyc[h_cyc.size()-1] + 1 && busy_at_done === 1'b0) passed++;
      else $display("FAIL full_done: done at %0d busy=%b, required one after last handshake with busy 0",
                    done_cyc, busy_at_done);
      total++;
      if (ahead_err == 0) passed++;
      else $display("FAIL full_ahead: %0d cycles raddr > head+2, required 0", ahead_err);
   endtask

   task automatic test_toggle_ready();
      int m;
      load_ramp();
      sweep(1, 1'b0, 1'b0);
      m = model_mismatches();
      total++;
      if (m == 0) passed++;
      else $display("FAIL toggle_seq: %0d bad words of %0d seen, required 0", m, h_addr.size());
      total++;
      if (stab_err == 0 && ahead_err == 0) passed++;
      else $display("FAIL toggle_stable: unstable=%0d ahead=%0d, required 0/0", stab_err, ahead_err);
      total++;
      if (csum_at_done === 32'h0000801C) passed++;
      else $display("FAIL toggle_csum: got %h, required 0000801c", csum_at_done);
   endtask

   task automatic test_stall();
      int m;
      load_ramp();
      sweep(2, 1'b0, 1'b0);
      total++;
      if (stall_err == 0 && stab_err == 0) passed++;
      else $display("FAIL stall_hold: bad stall cycles=%0d unstable=%0d, required 0/0", stall_err, stab_err);
      m = model_mismatches();
      total++;
      if (m == 0 && csum_at_done === 32'h0000801C) passed++;
      else $display("FAIL stall_resume: bad words=%0d csum=%h, required 0/0000801c", m, csum_at_done);
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      int m;
      load_ramp();
      @(negedge clk);
      start = 1'b1; ready = 1'b1;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (bus_a.out_valid && bus_a.out_addr == 3'd3) found = 1'b1;
      end
      total++;
      if (found) passed++;
      else $display("FAIL abort_reach: address 3 not presented within 30 cycles, required presented");
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (bus_a.out_valid === 1'b0 && bus_a.out_addr === 3'd0 && bus_a.out_data === 16'h0 &&
          bus_a.mem_raddr === 3'd0 && busy_a === 1'b0 && csum_a === 32'h0 && done_a === 1'b0)
         passed++;
      else $display("FAIL abort_clear: valid=%b addr=%0d data=%h raddr=%0d busy=%b csum=%h, required all 0",
                    bus_a.out_valid, bus_a.out_addr, bus_a.out_data, bus_a.mem_raddr, busy_a, csum_a);
      @(negedge clk);
      rst_n = 1'b1;
      sweep(0, 1'b0, 1'b0);
      m = model_mismatches();
      total++;
      if (m == 0 && csum_at_done === 32'h0000801C) passed++;
      else $display("FAIL abort_restart: bad words=%0d csum=%h, required 0/0000801c", m, csum_at_done);
   endtask

   task automatic test_start_ignored();
      int m;
      load_ramp();
      sweep(0, 1'b1, 1'b0);
      m = model_mismatches();
      total++;
      if (m == 0 && csum_at_done === 32'h0000801C) passed++;
      else $display("FAIL busy_start: bad words=%0d csum=%h, required 0/0000801c", m, csum_at_done);
      #1;
      total++;
      if (done_a === 1'b1 && csum_a === 32'h0000801C) passed++;
      else $display("FAIL done_hold: done=%b csum=%h, required 1/0000801c", done_a, csum_a);
      sweep(1, 1'b0, 1'b0);
      total++;
      if (k1_done === 1'b0 && k1_busy === 1'b1 && k1_csum === 32'h0) passed++;
      else $display("FAIL restart_clear: done=%b busy=%b csum=%h, required 0/1/0", k1_done, k1_busy, k1_csum);
      m = model_mismatches();
      total++;
      if (m == 0 && csum_at_done === 32'h0000801C) passed++;
      else $display("FAIL restart_seq: bad words=%0d csum=%h, required 0/0000801c", m, csum_at_done);
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      load_ramp();
      sweep(0, 1'b0, 1'b1);
      total++;
      if (h_cyc.size() == D && done_cyc == h_cyc[D-1] + 1) passed++;
      else $display("FAIL last_start_done: done at %0d, required one after last handshake", done_cyc);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         if (done_a !== 1'b1 || busy_a !== 1'b0 || bus_a.out_valid !== 1'b0) bad++;
      end
      total++;
      if (bad == 0) passed++;
      else $display("FAIL last_start_ignored: %0d cycles left DONE, required 0", bad);
   endtask

   task automatic test_wrap();
      load_ramp();
      sweep(3, 1'b0, 1'b0);
      total++;
      if (done_b_at_done === 1'b1 && csum_b_at_done === 16'hFFF8) passed++;
      else $display("FAIL wrap_csum: done=%b csum=%h, required 1/fff8", done_b_at_done, csum_b_at_done);
   endtask

   task automatic test_random();
      int m;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < D; i++) mem_a[i] = WD'($urandom);
         sweep(3, 1'b0, 1'b0);
         m = model_mismatches();
         total++;
         if (m == 0) passed++;
         else $display("FAIL rand_seq[%0d]: %0d bad words of %0d seen, required 0", r, m, h_addr.size());
         total++;
         if (csum_at_done === model_sum() && stab_err == 0) passed++;
         else $display("FAIL rand_csum[%0d]: csum=%h unstable=%0d, required %h/0",
                       r, csum_at_done, stab_err, model_sum());
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_toggle_ready();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
